// File: rtl/mem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: shares one memory port between the IF and MEM stages   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter #(
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        reset,
  // instruction fetch requester
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  // data requester
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic [63:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  // memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_MAX);
  localparam logic [3:0]    c_LATENCY    = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_owner_dm;
  logic [3:0]    r_lat;
  logic [SW-1:0] r_starve;
  logic          r_mem_en;
  logic          r_mem_we;
  logic          r_we;
  logic [63:0]   r_mem_addr;
  logic [63:0]   r_mem_wdata;
  logic [31:0]   r_if_rdata;
  logic [63:0]   r_dm_rdata;
  logic          r_if_valid;
  logic          r_dm_valid;

  logic          w_fetch_forced;
  logic          w_grant_dm;
  logic          w_grant_if;

  // Data normally wins (older instruction); a starved fetch overrides it.
  assign w_fetch_forced = if_req & dm_req & (r_starve == c_STARVE_MAX);
  assign w_grant_dm     = dm_req & ~w_fetch_forced;
  assign w_grant_if     = if_req & ~w_grant_dm;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner_dm  <= 1'b0;
      r_lat       <= 4'd0;
      r_starve    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_if_rdata  <= 32'd0;
      r_dm_rdata  <= 64'd0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_dm || w_grant_if) begin
            r_owner_dm <= w_grant_dm;
            r_we       <= w_grant_dm & dm_we;
            r_mem_we   <= w_grant_dm & dm_we;
            r_mem_en   <= 1'b1;
            r_state    <= ISSUE;
            if (w_grant_dm) begin
              r_mem_addr  <= dm_addr;
              r_mem_wdata <= dm_wdata;
              if (if_req && (r_starve != c_STARVE_MAX)) begin
                r_starve <= r_starve + SW'(1);
              end
            end else begin
              r_mem_addr <= if_addr;
              r_starve   <= '0;
            end
          end
        end
        ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_lat    <= c_LATENCY;
          r_state  <= WAIT;
        end
        WAIT: begin
          r_lat <= r_lat - 4'd1;
          // Counter at 1 marks the cycle in which mem_rdata is valid.
          if (r_lat == 4'd1) begin
            r_state <= RESP;
            if (r_owner_dm) begin
              r_dm_valid <= 1'b1;
              if (!r_we) begin
                r_dm_rdata <= mem_rdata;
              end
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= mem_rdata[31:0];
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_valid  = r_if_valid;
  assign dm_valid  = r_dm_valid;
  assign if_stall  = if_req & ~r_if_valid;
  assign dm_stall  = dm_req & ~r_dm_valid;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed vectors and corner sequences for arbiter   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.LATENCY(LAT), .STARVE_MAX(4)) dut (
    .CLK(CLK), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    case (a)
      64'h10:  return 64'hCAFE_0000_8B1F_03E0;
      64'h14:  return 64'h1111_2222_D503_201F;
      64'h40:  return 64'h0000_0000_0000_000F;
      64'h48:  return 64'h0123_4567_89AB_CDEF;
      default: return 64'hBAD0_0000_0000_0000 | a;
    endcase
  endfunction

  // Memory model: data only in the cycle LAT after the mem_en cycle, junk otherwise.
  int          cyc = 0;
  int          iss_cyc = -100;
  logic [63:0] iss_addr = 64'd0;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (mem_en === 1'b1) begin
      iss_cyc  = cyc;
      iss_addr = mem_addr;
    end
    mem_rdata = (cyc == iss_cyc + LAT) ? mem_fn(iss_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  logic prev_en = 1'b0;
  always @(negedge CLK) begin
    checks++;
    if ((prev_en === 1'b1 && mem_en === 1'b1) || (if_valid === 1'b1 && dm_valid === 1'b1)) begin
      errors++;
      $display("FAIL invariant: mem_en prev/now %b/%b if_valid %b dm_valid %b, required no back-to-back mem_en and no dual valid",
               prev_en, mem_en, if_valid, dm_valid);
    end
    prev_en = mem_en;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  typedef struct {
    logic        is_data;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [31:0] exp_if;
    logic [63:0] exp_dm;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v, input int idx);
    if (v.is_data) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk($sformatf("v%0d_stall_c0", idx), v.is_data ? dm_stall : if_stall, 64'd1);
    chk($sformatf("v%0d_en_c0", idx), mem_en, 64'd0);
    tick();
    chk($sformatf("v%0d_en_c1", idx), mem_en, 64'd1);
    chk($sformatf("v%0d_addr_c1", idx), mem_addr, v.addr);
    chk($sformatf("v%0d_we_c1", idx), mem_we, v.we);
    chk($sformatf("v%0d_busy_c1", idx), busy, 64'd1);
    if (v.we) chk($sformatf("v%0d_wdata_c1", idx), mem_wdata, v.wdata);
    for (int c = 2; c <= LAT + 1; c++) begin
      tick();
      chk($sformatf("v%0d_en_c%0d", idx, c), mem_en, 64'd0);
      chk($sformatf("v%0d_valid_c%0d", idx, c), v.is_data ? dm_valid : if_valid, 64'd0);
      chk($sformatf("v%0d_stall_c%0d", idx, c), v.is_data ? dm_stall : if_stall, 64'd1);
    end
    tick();
    chk($sformatf("v%0d_valid", idx), v.is_data ? dm_valid : if_valid, 64'd1);
    chk($sformatf("v%0d_other_valid", idx), v.is_data ? if_valid : dm_valid, 64'd0);
    chk($sformatf("v%0d_stall_resp", idx), v.is_data ? dm_stall : if_stall, 64'd0);
    chk($sformatf("v%0d_if_rdata", idx), if_rdata, v.exp_if);
    chk($sformatf("v%0d_dm_rdata", idx), dm_rdata, v.exp_dm);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk($sformatf("v%0d_valid_after", idx), {if_valid, dm_valid}, 64'd0);
    chk($sformatf("v%0d_busy_after", idx), busy, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          en_dm, en_if, dv, iv, ng, nv, dn, fn, nvld, vcyc;
    logic [63:0] dd, id;
    int          g[10];

    vt[0] = '{is_data:1'b0, we:1'b0, addr:64'h10, wdata:64'h0, exp_if:32'h8B1F03E0, exp_dm:64'h0};
    vt[1] = '{is_data:1'b1, we:1'b0, addr:64'h40, wdata:64'h0, exp_if:32'h8B1F03E0, exp_dm:64'hF};
    vt[2] = '{is_data:1'b1, we:1'b1, addr:64'h28, wdata:64'h1234_5678_9ABC_DEF0,
              exp_if:32'h8B1F03E0, exp_dm:64'hF};
    vt[3] = '{is_data:1'b0, we:1'b0, addr:64'h14, wdata:64'h0, exp_if:32'hD503201F, exp_dm:64'hF};
    vt[4] = '{is_data:1'b1, we:1'b0, addr:64'h48, wdata:64'h0, exp_if:32'hD503201F,
              exp_dm:64'h0123_4567_89AB_CDEF};
    vt[5] = '{is_data:1'b0, we:1'b0, addr:64'h10, wdata:64'h0, exp_if:32'h8B1F03E0,
              exp_dm:64'h0123_4567_89AB_CDEF};

    reset = 1'b1; if_req = 1'b0; if_addr = 64'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 64'd0; dm_wdata = 64'd0;
    tick();
    tick();
    chk("rst_ctrl", {mem_en, mem_we, if_valid, dm_valid, busy}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // Simultaneous requests: data first, then fetch.
    en_dm = -1; en_if = -1; dv = -1; iv = -1; dd = 64'd0; id = 64'd0;
    if_req = 1'b1; if_addr = 64'h14; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h40;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (mem_en && mem_addr == 64'h40) en_dm = c;
      if (mem_en && mem_addr == 64'h14) en_if = c;
      if (dm_valid) begin dv = c; dd = dm_rdata; dm_req = 1'b0; end
      if (if_valid) begin iv = c; id = {32'd0, if_rdata}; if_req = 1'b0; end
    end
    chk("sim_dm_en_cyc", 64'(en_dm), 64'd1);
    chk("sim_dm_valid_cyc", 64'(dv), 64'd4);
    chk("sim_dm_rdata", dd, 64'hF);
    chk("sim_if_en_cyc", 64'(en_if), 64'd6);
    chk("sim_if_valid_cyc", 64'(iv), 64'd9);
    chk("sim_if_rdata", id, 64'hD503201F);

    // Starvation: both requesters continuously busy.
    ng = 0; nv = 0; dn = 0; fn = 0;
    if_req = 1'b1; if_addr = 64'h1000; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h2000;
    for (int c = 1; c <= 80 && nv < 10; c++) begin
      tick();
      if (mem_en && ng < 10) begin
        g[ng] = (mem_addr < 64'h2000) ? 1 : 0;
        ng++;
      end
      if (dm_valid) begin nv++; dn++; dm_addr = 64'h2000 + 64'(8 * dn); end
      if (if_valid) begin nv++; fn++; if_addr = 64'h1000 + 64'(4 * fn); end
      if (nv == 10) begin if_req = 1'b0; dm_req = 1'b0; end
    end
    chk("starve_grants", 64'(ng), 64'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_g%0d_is_fetch", i), 64'(g[i]), (i == 4 || i == 9) ? 64'd1 : 64'd0);
    if_req = 1'b0; dm_req = 1'b0;

    // Reset in the middle of a fetch.
    tick();
    nvld = 0; vcyc = -1; id = 64'd0;
    if_req = 1'b1; if_addr = 64'h10;
    tick();
    if (if_valid) nvld++;
    tick();
    if (if_valid) nvld++;
    reset = 1'b1;
    tick();
    chk("mid_rst_ctrl", {mem_en, mem_we, if_valid, dm_valid, busy}, 64'd0);
    chk("mid_rst_addr", mem_addr, 64'd0);
    chk("mid_rst_wdata", mem_wdata, 64'd0);
    chk("mid_rst_rdata", {if_rdata, dm_rdata}, 64'd0);
    reset = 1'b0; if_req = 1'b0;
    tick();
    if (if_valid) nvld++;
    chk("mid_rst_no_valid", 64'(nvld), 64'd0);
    if_req = 1'b1; if_addr = 64'h14;
    nvld = 0;
    for (int c = 5; c <= 12; c++) begin
      tick();
      if (if_valid) begin nvld++; vcyc = c; id = {32'd0, if_rdata}; if_req = 1'b0; end
    end
    chk("post_rst_valid_count", 64'(nvld), 64'd1);
    chk("post_rst_valid_cyc", 64'(vcyc), 64'd8);
    chk("post_rst_rdata", id, 64'hD503201F);

    // Idle: nothing moves.
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("idle_c%0d", c), {mem_en, busy, if_valid, dm_valid}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
